// File: rtl/reg_read_32_if.sv
// Operand-read bus between decode/writeback and the register-read stage.
// Latency: none (wires only).
// Backpressure: Stall is driven by the slave back to decode.
// Signals: Q (flattened bank), Rs/Rt read addresses, Rd/Wreg/Issue issue info,
//          WbEn/WbAddr/WbData writeback, Stall/A/B/Valid/Err results.
interface reg_read_32_if;
    logic [1023:0] Q;
    logic [4:0]    Rs;
    logic [4:0]    Rt;
    logic [4:0]    Rd;
    logic          Issue;
    logic          Wreg;
    logic          WbEn;
    logic [4:0]    WbAddr;
    logic [31:0]   WbData;
    logic          Stall;
    logic [31:0]   A;
    logic [31:0]   B;
    logic          Valid;
    logic          Err;

    modport master (
        output Q, Rs, Rt, Rd, Issue, Wreg, WbEn, WbAddr, WbData,
        input  Stall, A, B, Valid, Err
    );

    modport slave (
        input  Q, Rs, Rt, Rd, Issue, Wreg, WbEn, WbAddr, WbData,
        output Stall, A, B, Valid, Err
    );
endinterface

// File: rtl/reg_read_32.sv
// Register-file read stage: two bypassed read ports latched into the ID/EX operand regs, with a pending-write scoreboard.
// Latency: 1 cycle from accept to A/B/Valid; Stall is combinational in the issue cycle.
// Backpressure: Stall holds decode while an operand's producer is outstanding or Rd's in-flight counter is full.
// Ports: Clk, Clrn (async active-low) plain; everything else on bus (reg_read_32_if.slave).
module reg_read_32 (
    input logic          Clk,
    input logic          Clrn,
    reg_read_32_if.slave bus
);

    logic [1:0]  cnt_q [32];
    logic [1:0]  cnt_d [32];
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        wb_live;
    logic        haz_a, haz_b, haz_dst;
    logic        stall_c;
    logic        accept;
    logic        inc;

    function automatic logic [31:0] resolve(input logic [1023:0] q, input logic [4:0] x,
                                            input logic wb_en, input logic [4:0] wb_addr,
                                            input logic [31:0] wb_data);
        if (x == 5'd0)
            return 32'd0;
        else if (wb_en && wb_addr == x)
            return wb_data;
        else
            return q[32*x +: 32];
    endfunction

    // The last outstanding write landing this cycle is forwarded, so it is not a hazard.
    function automatic logic op_hazard(input logic [4:0] x, input logic [1:0] c,
                                       input logic wb_en, input logic [4:0] wb_addr);
        return (x != 5'd0) && (c != 2'd0) && !(wb_en && wb_addr == x && c == 2'd1);
    endfunction

    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;

        wb_live = bus.WbEn && (bus.WbAddr != 5'd0);
        haz_a   = op_hazard(bus.Rs, cnt_q[bus.Rs], bus.WbEn, bus.WbAddr);
        haz_b   = op_hazard(bus.Rt, cnt_q[bus.Rt], bus.WbEn, bus.WbAddr);
        // A same-cycle writeback to Rd deliberately does not lift this: pre-edge count only.
        haz_dst = bus.Wreg && (bus.Rd != 5'd0) && (cnt_q[bus.Rd] == 2'd3);
        stall_c = bus.Issue && (haz_a || haz_b || haz_dst);
        accept  = bus.Issue && !stall_c;
        valid_d = accept;

        if (accept) begin
            a_d = resolve(bus.Q, bus.Rs, bus.WbEn, bus.WbAddr, bus.WbData);
            b_d = resolve(bus.Q, bus.Rt, bus.WbEn, bus.WbAddr, bus.WbData);
        end

        inc = accept && bus.Wreg && (bus.Rd != 5'd0);

        // Coincident increment and decrement cancel, including at zero (no underflow then).
        for (int i = 1; i < 32; i++) begin
            if (inc && bus.Rd == 5'(i) && !(wb_live && bus.WbAddr == 5'(i))) begin
                cnt_d[i] = cnt_q[i] + 2'd1;
            end else if (wb_live && bus.WbAddr == 5'(i) && !(inc && bus.Rd == 5'(i))) begin
                if (cnt_q[i] != 2'd0)
                    cnt_d[i] = cnt_q[i] - 2'd1;
                else
                    err_d = 1'b1;
            end
        end
        cnt_d[0] = 2'd0;
    end

    always_ff @(posedge Clk or negedge Clrn) begin
        if (!Clrn) begin
            cnt_q   <= '{default: 2'd0};
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.Stall = stall_c;
    assign bus.A     = a_q;
    assign bus.B     = b_q;
    assign bus.Valid = valid_q;
    assign bus.Err   = err_q;

endmodule
